i2c_avalon_regs: RTL and testbench

Avalon-MM register front-end that sits directly upstream of the I2C bit/byte engine. It is the HPS-facing slave behind the lightweight bridge.
- Buffers HPS command bytes in a TX FIFO and engine-received bytes in an RX FIFO.
- Holds the control and prescale registers.
- Hands commands to the engine over a valid/ready handshake.

---
 rtl/i2c_pkg.sv | 33 +++
 rtl/i2c_sync_fifo.sv | 55 +++++
 rtl/i2c_avalon_regs.sv | 113 +++++++++++
 tb/tb_i2c_avalon_regs.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared constants for the I2C Avalon register front-end: register map,
// STATUS bit positions and the layout of a TX command word.
package i2c_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_STATUS   = 2'd1;
  localparam logic [1:0] ADDR_CONTROL  = 2'd2;
  localparam logic [1:0] ADDR_PRESCALE = 2'd3;

  localparam int ST_TX_EMPTY = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_RX_EMPTY = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_BUSY     = 4;
  localparam int ST_ACK_ERR  = 5;
  localparam int ST_TX_OVF   = 6;
  localparam int ST_RX_OVF   = 7;

  localparam int CMD_START = 8;
  localparam int CMD_STOP  = 9;
  localparam int CMD_READ  = 10;
  localparam int CMD_NACK  = 11;
  localparam int CMD_W     = 12;

  typedef struct packed {
    logic       nack;
    logic       rd;
    logic       stop;
    logic       start;
    logic [7:0] data;
  } cmd_t;

endpackage

// File: rtl/i2c_sync_fifo.sv
// Single-clock FIFO with combinational head output. Clear beats any
// same-cycle push or pop; a full FIFO still accepts a push when it pops.
module i2c_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty & ~clr;
  assign do_push = push & (~full | (pop & ~empty)) & ~clr;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/i2c_avalon_regs.sv
// Avalon-MM slave in front of the I2C engine: TX command FIFO, RX byte FIFO,
// CONTROL/PRESCALE registers and sticky error flags.
module i2c_avalon_regs
  import i2c_pkg::*;
#(
  parameter int          TX_DEPTH     = 8,
  parameter int          RX_DEPTH     = 8,
  parameter logic [15:0] PRESCALE_RST = 16'd250
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        eng_enable,
  output logic [15:0] eng_prescale,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_byte,
  output logic        cmd_start,
  output logic        cmd_stop,
  output logic        cmd_read,
  output logic        cmd_nack,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  input  logic        eng_busy,
  input  logic        eng_ack_err
);
  logic       wr_en, rd_en, fifo_clr;
  logic       tx_push, tx_pop, tx_empty, tx_full;
  logic       rx_pop, rx_empty, rx_full;
  logic [7:0] rx_dout;
  cmd_t       tx_head;
  logic       ack_err, tx_ovf, rx_ovf;
  logic [2:0] w1c;
  logic [7:0] status;
  logic [31:0] rd_mux;
  logic       unused_wd;

  assign unused_wd = ^writedata[31:16];

  assign wr_en    = chipselect & write;
  assign rd_en    = chipselect & read;
  assign tx_push  = wr_en & (address == ADDR_DATA);
  assign rx_pop   = rd_en & (address == ADDR_DATA) & ~rx_empty;
  assign fifo_clr = wr_en & (address == ADDR_CONTROL) & writedata[1];
  assign w1c      = (wr_en & (address == ADDR_STATUS)) ? writedata[7:5] : 3'b000;

  assign cmd_valid = eng_enable & ~tx_empty;
  assign tx_pop    = cmd_valid & cmd_ready;
  assign cmd_byte  = tx_head.data;
  assign cmd_start = tx_head.start;
  assign cmd_stop  = tx_head.stop;
  assign cmd_read  = tx_head.rd;
  assign cmd_nack  = tx_head.nack;

  i2c_sync_fifo #(.WIDTH(CMD_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(tx_push), .pop(tx_pop), .clr(fifo_clr),
    .din(writedata[CMD_W-1:0]), .dout(tx_head), .empty(tx_empty), .full(tx_full)
  );

  i2c_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_valid), .pop(rx_pop), .clr(fifo_clr),
    .din(rx_byte), .dout(rx_dout), .empty(rx_empty), .full(rx_full)
  );

  always_comb begin
    status              = '0;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_TX_FULL]  = tx_full;
    status[ST_RX_EMPTY] = rx_empty;
    status[ST_RX_FULL]  = rx_full;
    status[ST_BUSY]     = eng_busy;
    status[ST_ACK_ERR]  = ack_err;
    status[ST_TX_OVF]   = tx_ovf;
    status[ST_RX_OVF]   = rx_ovf;
  end

  // Read mux sees pre-write register values, so a combined read+write returns the old value.
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:     rd_mux = rx_empty ? 32'd0 : {23'd0, 1'b1, rx_dout};
      ADDR_STATUS:   rd_mux = {24'd0, status};
      ADDR_CONTROL:  rd_mux = {31'd0, eng_enable};
      ADDR_PRESCALE: rd_mux = {16'd0, eng_prescale};
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata     <= '0;
      eng_enable   <= 1'b0;
      eng_prescale <= PRESCALE_RST;
      ack_err      <= 1'b0;
      tx_ovf       <= 1'b0;
      rx_ovf       <= 1'b0;
    end else begin
      if (rd_en) readdata <= rd_mux;
      if (wr_en && address == ADDR_CONTROL)  eng_enable   <= writedata[0];
      if (wr_en && address == ADDR_PRESCALE) eng_prescale <= writedata[15:0];
      // Set has priority over a same-cycle write-one-to-clear.
      ack_err <= eng_ack_err | (ack_err & ~w1c[0]);
      tx_ovf  <= (tx_push & tx_full & ~tx_pop & ~fifo_clr) | (tx_ovf & ~w1c[1]);
      rx_ovf  <= (rx_valid & rx_full & ~rx_pop & ~fifo_clr) | (rx_ovf & ~w1c[2]);
    end
  end

endmodule

// File: tb/tb_i2c_avalon_regs.sv
// Directed bench for i2c_avalon_regs: register map, command handshake,
// FIFO full/overflow, sticky flags and fifo_clr precedence.
module tb_i2c_avalon_regs;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect, read, write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        eng_enable;
  logic [15:0] eng_prescale;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  cmd_byte;
  logic        cmd_start, cmd_stop, cmd_read, cmd_nack;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        eng_busy, eng_ack_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i2c_avalon_regs dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata), .readdata(readdata),
    .eng_enable(eng_enable), .eng_prescale(eng_prescale),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_byte(cmd_byte),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_read(cmd_read),
    .cmd_nack(cmd_nack), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .eng_busy(eng_busy), .eng_ack_err(eng_ack_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; the DUT samples on the rising edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0; writedata = '0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    chk(tag, readdata, exp);
  endtask

  function automatic logic [12:0] head();
    return {cmd_valid, cmd_nack, cmd_read, cmd_stop, cmd_start, cmd_byte};
  endfunction

  initial begin
    reset = 1'b1; address = '0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    writedata = '0; cmd_ready = 1'b0; rx_valid = 1'b0; rx_byte = '0;
    eng_busy = 1'b0; eng_ack_err = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_enable", {31'd0, eng_enable}, 32'h0);
    chk("rst_prescale", {16'd0, eng_prescale}, 32'd250);
    chk("rst_cmd_valid", {31'd0, cmd_valid}, 32'h0);
    rd_chk("rst_status", 2'd1, 32'h05);
    rd_chk("rst_control", 2'd2, 32'h0);
    rd_chk("rst_prescale_rd", 2'd3, 32'd250);
    @(negedge clk);
    chk("readdata_hold", readdata, 32'd250);
    rd_chk("rst_data", 2'd0, 32'h0);

    // Command handshake with stall
    wr(2'd2, 32'h1);
    chk("enable_set", {31'd0, eng_enable}, 32'h1);
    wr(2'd0, 32'h1A0);
    wr(2'd0, 32'h2BB);
    for (int i = 0; i < 3; i++) begin
      chk("stall_head", {19'd0, head()}, 32'h11A0);
      @(negedge clk);
    end
    chk("stall_head_last", {19'd0, head()}, 32'h11A0);
    cmd_ready = 1'b1;
    @(negedge clk);
    chk("second_head", {19'd0, head()}, 32'h12BB);
    @(negedge clk);
    chk("drained_valid", {31'd0, cmd_valid}, 32'h0);
    cmd_ready = 1'b0;

    // TX fill with enable=0, overflow, then ordered drain
    wr(2'd2, 32'h0);
    for (int i = 0; i < 8; i++) wr(2'd0, 32'(i + 1));
    chk("tx_hold_disabled", {31'd0, cmd_valid}, 32'h0);
    rd_chk("tx_full_status", 2'd1, 32'h06);
    wr(2'd0, 32'h9);
    rd_chk("tx_ovf_status", 2'd1, 32'h46);
    wr(2'd2, 32'h1);
    cmd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_order", {19'd0, head()}, 32'h1000 | 32'(i + 1));
      @(negedge clk);
    end
    chk("drain_done", {31'd0, cmd_valid}, 32'h0);
    cmd_ready = 1'b0;
    wr(2'd1, 32'h40);
    rd_chk("tx_ovf_cleared", 2'd1, 32'h05);

    // RX path
    rx_valid = 1'b1; rx_byte = 8'h11;
    @(negedge clk);
    rx_byte = 8'h22;
    @(negedge clk);
    rx_valid = 1'b0;
    rd_chk("rx_pop_1", 2'd0, 32'h111);
    rd_chk("rx_pop_2", 2'd0, 32'h122);
    rd_chk("rx_pop_empty", 2'd0, 32'h000);
    rx_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      rx_byte = 8'(8'h30 + i);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    rd_chk("rx_ovf_status", 2'd1, 32'h89);

    // Sticky set beats same-cycle W1C
    eng_ack_err = 1'b1;
    chipselect = 1'b1; write = 1'b1; address = 2'd1; writedata = 32'h20;
    @(negedge clk);
    eng_ack_err = 1'b0; chipselect = 1'b0; write = 1'b0;
    rd_chk("ack_err_set_wins", 2'd1, 32'hA9);
    wr(2'd1, 32'h20);
    rd_chk("ack_err_cleared", 2'd1, 32'h89);
    wr(2'd1, 32'h80);
    eng_busy = 1'b1;
    rd_chk("busy_status", 2'd1, 32'h19);
    eng_busy = 1'b0;

    // fifo_clr with TX holding 3 and RX full; coincident RX push is discarded
    for (int i = 0; i < 3; i++) wr(2'd0, 32'h55);
    chk("tx_three_valid", {31'd0, cmd_valid}, 32'h1);
    rx_valid = 1'b1; rx_byte = 8'hEE;
    wr(2'd2, 32'h3);
    rx_valid = 1'b0;
    chk("clr_cmd_valid", {31'd0, cmd_valid}, 32'h0);
    chk("clr_enable", {31'd0, eng_enable}, 32'h1);
    rd_chk("clr_status", 2'd1, 32'h05);
    rd_chk("clr_control_rd", 2'd2, 32'h1);
    rd_chk("clr_data_rd", 2'd0, 32'h0);

    // Combined read+write returns the pre-write value
    chipselect = 1'b1; read = 1'b1; write = 1'b1; address = 2'd3; writedata = 32'h1234;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
    chk("rw_old_value", readdata, 32'd250);
    chk("rw_prescale_out", {16'd0, eng_prescale}, 32'h1234);
    rd_chk("rw_new_value", 2'd3, 32'h1234);

    // Accesses without chipselect are ignored
    write = 1'b1; address = 2'd3; writedata = 32'hBEEF;
    @(negedge clk);
    write = 1'b0;
    chk("no_cs_write", {16'd0, eng_prescale}, 32'h1234);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
